// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size encodings, FSM states and the latched request.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    MERGE  = 2'b10,
    RESP   = 2'b11
  } state_e;

  typedef struct packed {
    logic        we;
    size_e       size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/lsu_lane.sv
// Little-endian lane logic: extracts and extends a load from a memory word, and splices
// sub-word store data into a previously read word.
module lsu_lane
  import lsu_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] rd_word,
  input  logic [31:0] old_word,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // NOTE: every output and temporary gets a default before the case, so no path leaves one unassigned (no latch).
  always_comb begin
    byte_v     = rd_word[{addr_lo, 3'b000} +: 8];
    half_v     = rd_word[{addr_lo[1], 4'b0000} +: 16];
    load_data  = rd_word;
    merge_data = old_word;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{~is_unsigned & byte_v[7]}}, byte_v};
        merge_data[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data = {{16{~is_unsigned & half_v[15]}}, half_v};
        merge_data[{addr_lo[1], 4'b0000} +: 16] = wdata;
      end
      default: begin
        load_data  = rd_word;
        merge_data = old_word;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit driving a combinational-read data memory; sub-word stores use read-modify-write.
// Optional address range check enabled by defining LSU_BOUNDS_CHECK_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data
);

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        req_bad;
  logic        word_store;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  always_comb begin
    case (size_e'(req_size))
      SZ_BYTE: req_bad = 1'b0;
      SZ_HALF: req_bad = req_addr[0];
      SZ_WORD: req_bad = |req_addr[1:0];
      default: req_bad = 1'b1;
    endcase
`ifdef LSU_BOUNDS_CHECK_EN
    if (req_addr[31:2] >= 30'(MEM_WORDS)) req_bad = 1'b1;
`endif
  end

  assign word_store = req_q.we && (req_q.size == SZ_WORD);

  lsu_lane u_lane (
    .size        (req_q.size),
    .addr_lo     (req_q.addr[1:0]),
    .is_unsigned (req_q.uns),
    .rd_word     (read_data),
    .old_word    (word_q),
    .wdata       (req_q.wdata[15:0]),
    .load_data   (load_data),
    .merge_data  (merge_data)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d   = '{we: req_we, size: size_e'(req_size), uns: req_unsigned,
                      addr: req_addr, wdata: req_wdata};
          rdata_d = '0;
          err_d   = req_bad;
          state_d = req_bad ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (!req_q.we) begin
          rdata_d = load_data;
          state_d = RESP;
        end else if (word_store) begin
          state_d = RESP;
        end else begin
          word_d  = read_data;
          state_d = MERGE;
        end
      end
      MERGE: state_d = RESP;
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Memory controls decode straight from state so an asynchronous reset kills them at once.
  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_rdata  = rdata_q;
  assign rsp_err    = err_q;
  assign mem_read   = (state_q == ACCESS) && !word_store;
  assign mem_write  = ((state_q == ACCESS) && word_store) || (state_q == MERGE);
  assign address    = (state_q == ACCESS || state_q == MERGE) ? {req_q.addr[31:2], 2'b00} : '0;
  assign write_data = (state_q == MERGE) ? merge_data :
                      ((state_q == ACCESS) && word_store) ? req_q.wdata : '0;

endmodule
